// File: rtl/forwarding_hazard_unit.sv
// Forwarding/hazard control for the EX operand muxes: shadow pipeline slots, select codes, load-use stall.
// Optional HAZARD_STATS_EN adds a saturating stall_count output.
module forwarding_hazard_unit #(
  parameter int unsigned REG_ADDR_BITS  = 5,
  parameter int unsigned STALL_CNT_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_BITS-1:0] id_rs,
  input  logic [REG_ADDR_BITS-1:0] id_rt,
  input  logic [REG_ADDR_BITS-1:0] id_dest,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     stall,
  output logic [1:0]               fwd_a_sel,
  output logic [1:0]               fwd_b_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [STALL_CNT_BITS-1:0] stall_count
`endif
);

  typedef struct packed {
    logic                     valid;
    logic                     reg_write;
    logic                     mem_read;
    logic [REG_ADDR_BITS-1:0] dest;
  } slot_t;

  slot_t                    ex_q, ex_d;
  // MEM keeps only its liveness and dest; the WB slot never affects an output
  // (register file writes on the falling edge), so it is not stored.
  logic                     mem_live_q, mem_live_d;
  logic [REG_ADDR_BITS-1:0] mem_dest_q, mem_dest_d;
  logic [1:0]               fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0]               fwd_b_sel_q, fwd_b_sel_d;
  logic                     ex_live;
  logic                     bubble;

  function automatic logic [1:0] pick_sel(input logic                     ex_hit_live,
                                          input logic [REG_ADDR_BITS-1:0] ex_dest,
                                          input logic                     mem_hit_live,
                                          input logic [REG_ADDR_BITS-1:0] mem_dest,
                                          input logic [REG_ADDR_BITS-1:0] src);
    if (ex_hit_live && (ex_dest == src))
      return 2'b01;
    else if (mem_hit_live && (mem_dest == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    ex_live = ex_q.valid && ex_q.reg_write && (ex_q.dest != '0);
    stall   = id_valid && ex_live && ex_q.mem_read &&
              ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));
    bubble  = flush || stall || !id_valid;

    ex_d        = ex_q;
    mem_live_d  = mem_live_q;
    mem_dest_d  = mem_dest_q;
    fwd_a_sel_d = fwd_a_sel_q;
    fwd_b_sel_d = fwd_b_sel_q;

    if (!hold) begin
      mem_live_d = ex_live;
      mem_dest_d = ex_q.dest;
      if (bubble) begin
        ex_d        = '0;
        fwd_a_sel_d = 2'b00;
        fwd_b_sel_d = 2'b00;
      end else begin
        ex_d.valid     = 1'b1;
        ex_d.reg_write = id_reg_write;
        ex_d.mem_read  = id_mem_read;
        ex_d.dest      = id_dest;
        fwd_a_sel_d    = pick_sel(ex_live, ex_q.dest, mem_live_q, mem_dest_q, id_rs);
        fwd_b_sel_d    = pick_sel(ex_live, ex_q.dest, mem_live_q, mem_dest_q, id_rt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_live_q  <= 1'b0;
      mem_dest_q  <= '0;
      fwd_a_sel_q <= 2'b00;
      fwd_b_sel_q <= 2'b00;
    end else begin
      ex_q        <= ex_d;
      mem_live_q  <= mem_live_d;
      mem_dest_q  <= mem_dest_d;
      fwd_a_sel_q <= fwd_a_sel_d;
      fwd_b_sel_q <= fwd_b_sel_d;
    end
  end

  assign fwd_a_sel = fwd_a_sel_q;
  assign fwd_b_sel = fwd_b_sel_q;

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_BITS-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !hold && (stall_count_q != '1))
      stall_count_d = stall_count_q + STALL_CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_count_q <= '0;
    else
      stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Table-driven bench for forwarding_hazard_unit with a queue scoreboard for the registered selects.
module tb_forwarding_hazard_unit;
  localparam int unsigned RB = 5;
  localparam int unsigned CB = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0;
  logic [RB-1:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic          hold = 1'b0, flush = 1'b0;
  logic          stall;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_STATS_EN
  logic [CB-1:0] stall_count;
`endif

  forwarding_hazard_unit #(.REG_ADDR_BITS(RB), .STALL_CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .hold(hold), .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rst, hld, fl, v;
    logic [RB-1:0] rs, rt, dest;
    logic          rw, mr;
    logic          exp_stall;
    logic [1:0]    exp_a, exp_b;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];
  int         errors = 0;
  int         checks = 0;
  int         exp_cnt = 0;

  function automatic vec_t mk(string n, logic rst, logic hld, logic fl, logic v,
                              logic [RB-1:0] rs, logic [RB-1:0] rt, logic [RB-1:0] dest,
                              logic rw, logic mr, logic st, logic [1:0] a, logic [1:0] b);
    vec_t r;
    r.name = n; r.rst = rst; r.hld = hld; r.fl = fl; r.v = v;
    r.rs = rs; r.rt = rt; r.dest = dest; r.rw = rw; r.mr = mr;
    r.exp_stall = st; r.exp_a = a; r.exp_b = b;
    return r;
  endfunction

  function automatic vec_t nop();
    return mk("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
  endfunction

  task automatic step(input vec_t r);
    logic [3:0] want;
    @(negedge clk);
    reset = r.rst; hold = r.hld; flush = r.fl; id_valid = r.v;
    id_rs = r.rs; id_rt = r.rt; id_dest = r.dest;
    id_reg_write = r.rw; id_mem_read = r.mr;
    #1;
    checks++;
    if (stall !== r.exp_stall) begin
      errors++;
      $display("FAIL %s stall got=%0b want=%0b", r.name, stall, r.exp_stall);
    end
    sb.push_back({r.exp_a, r.exp_b});
    if (r.rst) exp_cnt = 0;
    else if (r.exp_stall && !r.hld && exp_cnt < (2 ** CB) - 1) exp_cnt++;
    @(posedge clk);
    #1;
    want = sb.pop_front();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== want) begin
      errors++;
      $display("FAIL %s fwd a/b got=%b/%b want=%b/%b", r.name, fwd_a_sel, fwd_b_sel,
               want[3:2], want[1:0]);
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_count !== CB'(exp_cnt)) begin
      errors++;
      $display("FAIL %s stall_count got=%0d want=%0d", r.name, stall_count, exp_cnt);
    end
`endif
  endtask

  initial begin
    vecs.push_back(mk("reset",        1,0,0,0, 0,0,0, 0,0, 0,2'b00,2'b00));
    vecs.push_back(mk("t1_add8",      0,0,0,1, 1,2,8, 1,0, 0,2'b00,2'b00));
    vecs.push_back(mk("t1_sub9",      0,0,0,1, 8,3,9, 1,0, 0,2'b01,2'b00));
    vecs.push_back(nop()); vecs.push_back(nop());
    vecs.push_back(mk("t2_add8",      0,0,0,1, 1,2,8, 1,0, 0,2'b00,2'b00));
    vecs.push_back(nop());
    vecs.push_back(mk("t2_or10",      0,0,0,1, 4,8,10,1,0, 0,2'b00,2'b10));
    vecs.push_back(nop()); vecs.push_back(nop());
    vecs.push_back(mk("t3_lw8",       0,0,0,1, 1,0,8, 1,1, 0,2'b00,2'b00));
    vecs.push_back(mk("t3_add_stall", 0,0,0,1, 8,8,9, 1,0, 1,2'b00,2'b00));
    vecs.push_back(mk("t3_add_go",    0,0,0,1, 8,8,9, 1,0, 0,2'b10,2'b10));
    vecs.push_back(nop()); vecs.push_back(nop());
    vecs.push_back(mk("t4_add0",      0,0,0,1, 1,2,0, 1,0, 0,2'b00,2'b00));
    vecs.push_back(mk("t4_sub3",      0,0,0,1, 0,0,3, 1,0, 0,2'b00,2'b00));
    vecs.push_back(nop());
    vecs.push_back(mk("t4_lw0",       0,0,0,1, 1,0,0, 1,1, 0,2'b00,2'b00));
    vecs.push_back(mk("t4_use0",      0,0,0,1, 0,0,4, 1,0, 0,2'b00,2'b00));
    vecs.push_back(nop()); vecs.push_back(nop());
    vecs.push_back(mk("h_add5",       0,0,0,1, 1,2,5, 1,0, 0,2'b00,2'b00));
    vecs.push_back(mk("h_lw8",        0,0,0,1, 5,0,8, 1,1, 0,2'b01,2'b00));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("h_dep_hold", 0,1,0,1, 8,5,9, 1,0, 1,2'b01,2'b00));
    vecs.push_back(mk("h_dep_stall",  0,0,0,1, 8,5,9, 1,0, 1,2'b00,2'b00));
    vecs.push_back(mk("h_dep_go",     0,0,0,1, 8,5,9, 1,0, 0,2'b10,2'b00));
    vecs.push_back(nop()); vecs.push_back(nop());
    vecs.push_back(mk("f_lw8",        0,0,0,1, 1,0,8, 1,1, 0,2'b00,2'b00));
    vecs.push_back(mk("f_dep_flush",  0,0,1,1, 8,8,9, 1,0, 1,2'b00,2'b00));
    vecs.push_back(mk("f_after",      0,0,0,0, 0,0,0, 0,0, 0,2'b00,2'b00));
    vecs.push_back(nop());
    vecs.push_back(mk("r_lw8",        0,0,0,1, 1,0,8, 1,1, 0,2'b00,2'b00));
    vecs.push_back(mk("r_dep_reset",  1,0,0,1, 8,8,9, 1,0, 1,2'b00,2'b00));
    vecs.push_back(mk("r_dep_after",  0,0,0,1, 8,8,9, 1,0, 0,2'b00,2'b00));
    vecs.push_back(nop());

    foreach (vecs[i]) step(vecs[i]);

`ifdef HAZARD_STATS_EN
    for (int i = 0; i < 9; i++) begin
      step(mk("s_lw8",    0,0,0,1, 1,0,8, 1,1, 0,2'b00,2'b00));
      step(mk("s_stall",  0,0,0,1, 8,8,9, 1,0, 1,2'b00,2'b00));
      step(mk("s_go",     0,0,0,1, 8,8,9, 1,0, 0,2'b10,2'b10));
      step(nop());
    end
    checks++;
    if (stall_count !== CB'((2 ** CB) - 1)) begin
      errors++;
      $display("FAIL sat_count got=%0d want=%0d", stall_count, (2 ** CB) - 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Control-side counterpart of the pipeline 3-to-1 operand multiplexers.
- Tracks destination-register info of in-flight instructions in shadow EX/MEM/WB slots.
- Generates the 2-bit operand-select codes for the instruction entering EX.
- Detects load-use hazards and raises a one-cycle stall that freezes PC and IF/ID and inserts a bubble.

Parameters:
- REG_ADDR_BITS, 5, register specifier width.
- STALL_CNT_BITS, 16, width of stall statistics counter (optional feature only).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high; clears all state on the rising edge where it is high.
- id_valid, input, 1, the ID stage holds a real instruction.
- id_rs, input, REG_ADDR_BITS, source register A of the ID instruction.
- id_rt, input, REG_ADDR_BITS, source register B of the ID instruction.
- id_dest, input, REG_ADDR_BITS, destination register of the ID instruction.
- id_reg_write, input, 1, the ID instruction writes the register file.
- id_mem_read, input, 1, the ID instruction is a load.
- hold, input, 1, global pipeline freeze (memory wait).
- flush, input, 1, kill the ID instruction (taken branch/jump).
- stall, output, 1, combinational load-use stall to PC/IF-ID enables.
- fwd_a_sel, output, 2, registered select for EX operand A mux.
- fwd_b_sel, output, 2, registered select for EX operand B mux.

Behaviour:
- Select encoding:
  - 2'b00: ID/EX register-file data.
  - 2'b01: EX/MEM ALU result.
  - 2'b10: MEM/WB write-back data.
  - 2'b11: never driven.
- Shadow slots EX, MEM, WB each hold {valid, reg_write, mem_read, dest}.
- Reset:
  - All slot fields go to 0.
  - fwd_a_sel = fwd_b_sel = 2'b00.
  - stall = 0 in the cycle following reset.
  - A reset mid-stall or mid-hold aborts immediately; no pending stall survives.
- Live slot: valid && reg_write && dest != 0. Register 0 is never forwarded and never causes a stall.
- stall (combinational), asserted when all of the following hold:
  - id_valid is high.
  - EX slot is live and mem_read = 1.
  - EX.dest == id_rs or EX.dest == id_rt.
  - stall is not gated by hold or flush.
- Rising edge with hold = 1: all slots and fwd_*_sel keep their values.
- Rising edge with hold = 0:
  - WB <= MEM, MEM <= EX.
  - EX <= bubble (all 0) if flush || stall || !id_valid; otherwise EX <= ID fields.
  - fwd_a_sel <= 2'b01 if EX slot is live and EX.dest == id_rs.
  - Else fwd_a_sel <= 2'b10 if MEM slot is live and MEM.dest == id_rs.
  - Else fwd_a_sel <= 2'b00.
  - fwd_b_sel follows the same rules using id_rt.
  - When a bubble is inserted, fwd_a_sel and fwd_b_sel <= 2'b00.
- Priority: the most recent producer (EX) wins over MEM when both match.
- Forwarding rationale: the instruction in EX moves to MEM as the ID instruction enters EX, hence code 01. MEM moves to WB, hence code 10.
- WB-to-ID hazards need no forwarding: the register file writes on the falling edge.
- Load-use stall length: exactly 1 cycle.
  - The next cycle sees the bubble in EX and the load in MEM.
  - The dependent operand then receives code 10 on the following advance.
- Event priority: reset > hold > flush > stall.
  - flush together with stall: a bubble is inserted once; stall still deasserts only once EX no longer holds the load.
- Latency: fwd_*_sel valid in the same cycle the instruction occupies EX (one edge after it was in ID).

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds output stall_count [STALL_CNT_BITS-1:0]:
  - Increments on each rising edge where stall = 1 and hold = 0.
  - Saturates at all-ones; no wrap.
  - Cleared by reset.
- When undefined: no port, no counter logic; all other behaviour is identical.

Test Plan:
- add $8,$1,$2 then sub $9,$8,$3 -> when sub is in EX, fwd_a_sel = 01, fwd_b_sel = 00, stall never high.
- add $8 then nop then or $10,$4,$8 -> when or is in EX, fwd_b_sel = 10.
- lw $8 then add $9,$8,$8 -> stall = 1 for exactly one cycle and a bubble enters EX. When add reaches EX, fwd_a_sel = fwd_b_sel = 10. With HAZARD_STATS_EN, stall_count = 1.
- add $0,$1,$2 then sub $3,$0,$0 -> fwd selects 00, stall 0. Also add $5 followed by lw-dependent sequence with hold = 1 for 3 cycles -> slots and selects frozen, stall held.
- lw $8 with a dependent instruction in ID and flush = 1 in the same cycle -> bubble inserted, dependent killed, no forwarding codes nonzero next cycle.
- reset asserted during a load-use stall -> next cycle stall = 0, fwd selects 00, all slots empty (a following dependent instruction gets 00).
